// File: rtl/instr_pkg.sv
// Shared opcode/function definitions for the encoder issuer and the
// downstream decoder: widths, function-to-opcode table, issue states.
package instr_pkg;

  localparam int OPCODE_W = 4;
  localparam int FUNC_W   = 14;

  // Function index -> opcode; 0x9 and 0xE are reserved and never used.
  localparam logic [OPCODE_W-1:0] FUNC2OP [FUNC_W] = '{
    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
    4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF
  };

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } enc_state_e;

  function automatic logic [OPCODE_W-1:0] func2op(
    input logic [3:0] idx
  );
    logic [OPCODE_W-1:0] op;
    op = '0;
    for (int i = 0; i < FUNC_W; i++) begin
      if (idx == 4'(i)) op = FUNC2OP[i];
    end
    return op;
  endfunction

endpackage

// File: rtl/enc_prio14.sv
// Lowest-set-bit priority encoder over the 14-bit pending vector.
// Ports: pending in; low_idx, onehot_low, any, single out.
module enc_prio14
  import instr_pkg::*;
(
  input  logic [FUNC_W-1:0] pending,
  output logic [3:0]        low_idx,
  output logic [FUNC_W-1:0] onehot_low,
  output logic              any,
  output logic              single
);

  always_comb begin
    low_idx = '0;
    for (int i = FUNC_W - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = 4'(i);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_low = pending & (~pending + FUNC_W'(1));
  assign any        = |pending;
  assign single     = any &&
    ((pending & (pending - FUNC_W'(1))) == '0);

endmodule

// File: rtl/instruction_encoder_issuer.sv
// Latches a 14-bit function-request vector and issues one opcode per set
// bit, lowest index first, over valid/ready. Ports: clk, rst_n, flush,
// req_valid/req_vec/req_ready, op_valid/op_code/op_last/op_ready, done,
// err_empty, and issue_cnt when ENC_ISSUE_COUNT_EN is defined.
module instruction_encoder_issuer
  import instr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                req_valid,
  input  logic [FUNC_W-1:0]   req_vec,
  output logic                req_ready,
  output logic                op_valid,
  output logic [OPCODE_W-1:0] op_code,
  output logic                op_last,
  input  logic                op_ready,
  output logic                done,
`ifdef ENC_ISSUE_COUNT_EN
  output logic [CNT_W-1:0]    issue_cnt,
`endif
  output logic                err_empty
);

  enc_state_e        state_q, state_d;
  logic [FUNC_W-1:0] pending_q, pending_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [3:0]        low_idx;
  logic [FUNC_W-1:0] onehot_low;
  logic              any_set;
  logic              single_set;

  enc_prio14 u_prio (
    .pending    (pending_q),
    .low_idx    (low_idx),
    .onehot_low (onehot_low),
    .any        (any_set),
    .single     (single_set)
  );

  assign req_ready = (state_q == IDLE);
  assign op_valid  = (state_q == ISSUE);
  assign op_code   = (op_valid && any_set) ? func2op(low_idx) : '0;
  assign op_last   = op_valid && single_set;
  assign done      = done_q;
  assign err_empty = err_q;

`ifdef ENC_ISSUE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign issue_cnt = cnt_q;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef ENC_ISSUE_COUNT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!flush && req_valid) begin
          if (req_vec == '0) begin
            err_d = 1'b1;
          end else begin
            pending_d = req_vec;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Flush overrides a simultaneous handshake: nothing issued.
        if (flush) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (op_ready) begin
          pending_d = pending_q & ~onehot_low;
`ifdef ENC_ISSUE_COUNT_EN
          cnt_d     = cnt_q + CNT_W'(1);
`endif
          if (single_set) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ENC_ISSUE_COUNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef ENC_ISSUE_COUNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_encoder_issuer.sv
// Directed scoreboard bench for instruction_encoder_issuer.
// Expected opcodes are queued at request time and popped on handshake.
module tb_instruction_encoder_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic [13:0] req_vec;
  logic        req_ready;
  logic        op_valid;
  logic [3:0]  op_code;
  logic        op_last;
  logic        op_ready;
  logic        done;
  logic        err_empty;
`ifdef ENC_ISSUE_COUNT_EN
  logic [7:0]  issue_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [4:0] exp_q [$];

  instruction_encoder_issuer #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_vec   (req_vec),
    .req_ready (req_ready),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .op_last   (op_last),
    .op_ready  (op_ready),
    .done      (done),
`ifdef ENC_ISSUE_COUNT_EN
    .issue_cnt (issue_cnt),
`endif
    .err_empty (err_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_map(input int i);
    logic [3:0] t [14];
    t = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
          4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
    return t[i];
  endfunction

  task automatic send(input logic [13:0] v);
    int n;
    int k;
    n = $countones(v);
    k = 0;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) begin
        k++;
        exp_q.push_back({ref_map(i), k == n});
      end
    end
    chk("req_ready_before_send", 16'(req_ready), 16'd1);
    req_valid = 1'b1;
    req_vec   = v;
    step();
    req_valid = 1'b0;
    req_vec   = 14'($urandom);
    chk("op_valid_after_accept", 16'(op_valid), 16'd1);
  endtask

  task automatic run_ops(input int budget);
    logic [4:0] e;
    logic       was_last;
    int         c;
    c = 0;
    while ((exp_q.size() != 0 || op_valid) && c < budget) begin
      was_last = 1'b0;
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_op", 16'(op_code), 16'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("op_code", 16'(op_code), 16'(e[4:1]));
          chk("op_last", 16'(op_last), 16'(e[0]));
          was_last = op_last;
          exp_cnt++;
        end
      end
      step();
      chk("done_pulse", 16'(done), 16'(was_last));
      if (was_last) chk("req_ready_after_done", 16'(req_ready), 16'd1);
      c++;
    end
    chk("run_ops_in_budget", 16'(c < budget), 16'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_vec   = '0;
    op_ready  = 1'b1;
    #12;
    chk("rst_req_ready", 16'(req_ready), 16'd1);
    chk("rst_op_valid",  16'(op_valid),  16'd0);
    chk("rst_op_code",   16'(op_code),   16'd0);
    chk("rst_op_last",   16'(op_last),   16'd0);
    chk("rst_done",      16'(done),      16'd0);
    chk("rst_err_empty", 16'(err_empty), 16'd0);
    rst_n = 1'b1;
    step();

    // Single request.
    send(14'h0001);
    run_ops(10);

    // Upper map range, including the 0x9/0xE gaps.
    send(14'h3E00);
    run_ops(20);

    // Backpressure: held opcode stays stable.
    op_ready = 1'b0;
    send(14'h0105);
    for (int i = 0; i < 3; i++) begin
      chk("bp_op_valid", 16'(op_valid), 16'd1);
      chk("bp_op_code",  16'(op_code),  16'h0);
      step();
      chk("bp_no_done", 16'(done), 16'd0);
    end
    op_ready = 1'b1;
    run_ops(20);

    // Empty vector.
    req_valid = 1'b1;
    req_vec   = '0;
    step();
    req_valid = 1'b0;
    chk("empty_err",       16'(err_empty), 16'd1);
    chk("empty_op_valid",  16'(op_valid),  16'd0);
    chk("empty_req_ready", 16'(req_ready), 16'd1);
    step();
    chk("empty_err_clear", 16'(err_empty), 16'd0);

    // Flush in IDLE blocks acceptance.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_vec   = '0;
    step();
    chk("idle_flush_no_err", 16'(err_empty), 16'd0);
    req_vec = 14'h0003;
    step();
    chk("idle_flush_no_accept", 16'(op_valid), 16'd0);
    flush     = 1'b0;
    req_valid = 1'b0;

    // Flush mid-ISSUE on the 3rd opcode.
    send(14'h00FF);
    exp_q.delete();
    chk("fl_op0", 16'(op_code), 16'h0);
    step();
    chk("fl_op1", 16'(op_code), 16'h1);
    step();
    chk("fl_op2", 16'(op_code), 16'h2);
    exp_cnt += 2;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_op_valid",  16'(op_valid),  16'd0);
    chk("fl_no_done",   16'(done),      16'd0);
    chk("fl_req_ready", 16'(req_ready), 16'd1);
`ifdef ENC_ISSUE_COUNT_EN
    chk("fl_issue_cnt", 16'(issue_cnt), 16'(exp_cnt));
`endif
    step();

    // Asynchronous reset mid-ISSUE.
    op_ready = 1'b0;
    send(14'h3E00);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_op_valid",  16'(op_valid),  16'd0);
    chk("arst_req_ready", 16'(req_ready), 16'd1);
    #1 rst_n = 1'b1;
    exp_cnt = 0;
    op_ready = 1'b1;
    step();
    chk("arst_no_done",   16'(done),      16'd0);
    chk("arst_req_ready2", 16'(req_ready), 16'd1);
`ifdef ENC_ISSUE_COUNT_EN
    chk("arst_issue_cnt", 16'(issue_cnt), 16'd0);
`endif

    // Traffic after reset: lowest and highest functions.
    send(14'h2001);
    run_ops(10);
`ifdef ENC_ISSUE_COUNT_EN
    chk("final_issue_cnt", 16'(issue_cnt), 16'(exp_cnt));
`endif
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
